// File: rtl/pipeline_pkg.sv
// Shared types and constants for the MEM/WB writeback slice: control struct,
// writeback source encodings, load funct3 codes and the stage FSM states.
package pipeline_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef struct packed {
    logic              reg_write;
    logic [REG_AW-1:0] dest_reg;
    logic [1:0]        wb_sel;
    logic [2:0]        load_funct3;
  } wb_ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] loaded_data;
    logic [XLEN-1:0] alu_data;
    logic [XLEN-1:0] pc_plus4;
    wb_ctrl_t        ctrl;
  } mem_wb_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LATCHED   = 2'd1,
    WRITE     = 2'd2,
    WAIT_DROP = 2'd3
  } wb_state_t;

  // Access size in bytes; funct3=111 decodes as a doubleword.
  function automatic logic [3:0] load_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage to writeback-stage bundle, including the register-file write
// port and retire outputs. The stage itself uses the slave modport.
interface writeback_stage_if;
  import pipeline_pkg::*;

  logic              memory_done;
  logic              flush;
  logic [XLEN-1:0]   loaded_data;
  logic [XLEN-1:0]   alu_data;
  logic [XLEN-1:0]   pc_plus4;
  wb_ctrl_t          wb_ctrl;
  logic              mem_wb_pipeline_valid;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic              wb_done;
  logic              wb_misaligned;
  logic [63:0]       retired_count;

  modport master (
    output memory_done, flush, loaded_data, alu_data, pc_plus4, wb_ctrl,
    input  mem_wb_pipeline_valid, rf_we, rf_waddr, rf_wdata, wb_done,
           wb_misaligned, retired_count
  );

  modport slave (
    input  memory_done, flush, loaded_data, alu_data, pc_plus4, wb_ctrl,
    output mem_wb_pipeline_valid, rf_we, rf_waddr, rf_wdata, wb_done,
           wb_misaligned, retired_count
  );
endinterface

// File: rtl/writeback_stage_load_extract.sv
// Combinational load alignment: shifts the addressed bytes down, sign- or
// zero-extends them, and flags accesses that run past the doubleword.
module load_extract
  import pipeline_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] value,
  output logic            crosses
);

  logic [XLEN-1:0] shifted;
  logic [3:0]      end_byte;

  always_comb begin
    shifted  = raw >> {offset, 3'b000};
    end_byte = {1'b0, offset} + load_size(funct3);
    crosses  = (end_byte > 4'd8);
    case (funct3)
      F3_LB:   value = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   value = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   value = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_LBU:  value = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:  value = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_LWU:  value = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: value = shifted;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback: latches one memory-stage result per
// memory_done level, computes the write value, pulses the register-file write.
module writeback_stage
  import pipeline_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  writeback_stage_if.slave  wb
);

  wb_state_t         state_reg, state_next;
  mem_wb_t           mem_wb_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic [REG_AW-1:0] waddr_reg;
  logic              we_ok_reg;
  logic              misaligned_reg;
  logic [63:0]       retired_reg;

  logic [XLEN-1:0]   load_value;
  logic              load_cross;
  logic [XLEN-1:0]   wb_value_next;
  logic              misaligned_next;
  logic              capture;
  logic              retire;

  load_extract u_load_extract (
    .raw     (mem_wb_reg.loaded_data),
    .offset  (mem_wb_reg.alu_data[2:0]),
    .funct3  (mem_wb_reg.ctrl.load_funct3),
    .value   (load_value),
    .crosses (load_cross)
  );

  always_comb begin
    state_next      = state_reg;
    capture         = 1'b0;
    retire          = 1'b0;
    wb_value_next   = mem_wb_reg.alu_data;
    misaligned_next = 1'b0;

    // Only loads can be misaligned; wb_sel=3 falls back to the ALU result.
    case (mem_wb_reg.ctrl.wb_sel)
      WB_MEM: begin
        wb_value_next   = load_value;
        misaligned_next = load_cross;
      end
      WB_PC4:  wb_value_next = mem_wb_reg.pc_plus4;
      default: ;
    endcase

    case (state_reg)
      IDLE: begin
        if (wb.memory_done && !wb.flush) begin
          capture    = 1'b1;
          state_next = LATCHED;
        end
      end
      LATCHED:   state_next = wb.flush ? WAIT_DROP : WRITE;
      WRITE: begin
        retire     = !wb.flush;
        state_next = WAIT_DROP;
      end
      // Hold here until the producer drops its level so it is not latched twice.
      WAIT_DROP: if (!wb.memory_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      mem_wb_reg     <= '0;
      wdata_reg      <= '0;
      waddr_reg      <= '0;
      we_ok_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
      retired_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        mem_wb_reg.loaded_data <= wb.loaded_data;
        mem_wb_reg.alu_data    <= wb.alu_data;
        mem_wb_reg.pc_plus4    <= wb.pc_plus4;
        mem_wb_reg.ctrl        <= wb.wb_ctrl;
      end
      if (state_reg == LATCHED && !wb.flush) begin
        wdata_reg      <= wb_value_next;
        waddr_reg      <= mem_wb_reg.ctrl.dest_reg;
        we_ok_reg      <= mem_wb_reg.ctrl.reg_write &&
                          (mem_wb_reg.ctrl.dest_reg != '0) && !misaligned_next;
        misaligned_reg <= misaligned_next;
      end
      if (retire) retired_reg <= retired_reg + 64'd1;
    end
  end

  assign wb.mem_wb_pipeline_valid = (state_reg != IDLE);
  assign wb.rf_we                 = retire && we_ok_reg;
  assign wb.rf_waddr              = waddr_reg;
  assign wb.rf_wdata              = wdata_reg;
  assign wb.wb_done               = retire;
  assign wb.wb_misaligned         = retire && misaligned_reg;
  assign wb.retired_count         = retired_reg;

endmodule
